// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads instruction memory combinationally and
// queues {pc, word} pairs in a small circular prefetch buffer for decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  output logic        imem_we,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0] buf_pc_q   [DEPTH];
  logic [31:0] buf_word_q [DEPTH];

  logic pop;
  logic push;

  // Only the word-aligned part of the redirect target is used.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign imem_addr   = pc_q;
  assign imem_we     = 1'b0;
  assign instr_valid = (count_q != '0);

  // Outputs come only from registered state, never from instr_ready.
  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (instr_valid) begin
      instr    = buf_word_q[rd_ptr_q];
      instr_pc = buf_pc_q[rd_ptr_q];
    end
  end

  assign pop  = instr_valid && instr_ready;
  assign push = !redirect && ((count_q < DepthCnt) || pop);

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      buf_pc_q[wr_ptr_q]   <= pc_q;
      buf_word_q[wr_ptr_q] <= imem_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: expected PCs are queued when
// reset/redirect is driven and compared as decode accepts each instruction.
module tb_instruction_fetch;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic        imem_we;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int n_checks = 0;
  int n_pass   = 0;
  logic we_bad = 1'b0;
  logic [31:0] exp_q[$];

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_addr   (imem_addr),
    .imem_we     (imem_we),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word at A is A000_0000 | A.
  always_comb imem_data = 32'hA000_0000 | imem_addr;

  always @(negedge clk) if (imem_we !== 1'b0) we_bad <= 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic reset_dut(input logic rdy);
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = rdy;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called at a negedge with instr_ready high; expects one delivery per cycle.
  task automatic drain(input int n, input string tag);
    logic [31:0] epc;
    for (int i = 0; i < n; i++) begin
      epc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_checks++;
      if (instr_valid !== 1'b1)
        $display("FAIL %s valid[%0d]: got %b want 1", tag, i, instr_valid);
      else n_pass++;
      n_checks++;
      if (instr_pc !== epc)
        $display("FAIL %s instr_pc[%0d]: got %h want %h", tag, i, instr_pc, epc);
      else n_pass++;
      n_checks++;
      if (instr !== (32'hA000_0000 | epc))
        $display("FAIL %s instr[%0d]: got %h want %h", tag, i, instr, 32'hA000_0000 | epc);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_stream();
    reset_dut(1'b1);
    n_checks++;
    if (instr_valid !== 1'b0) $display("FAIL reset valid: got %b want 0", instr_valid);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 32'h0) $display("FAIL reset imem_addr: got %h want 0", imem_addr);
    else n_pass++;
    n_checks++;
    if (instr !== 32'h0) $display("FAIL reset instr: got %h want 0", instr);
    else n_pass++;
    n_checks++;
    if (instr_pc !== 32'h0) $display("FAIL reset instr_pc: got %h want 0", instr_pc);
    else n_pass++;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    @(negedge clk);
    drain(4, "stream");
  endtask

  task automatic test_backpressure_full_pop();
    reset_dut(1'b0);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    repeat (5) @(negedge clk);
    n_checks++;
    if (imem_addr !== 32'h8) $display("FAIL bp imem_addr: got %h want 00000008", imem_addr);
    else n_pass++;
    n_checks++;
    if (instr_pc !== 32'h0) $display("FAIL bp instr_pc: got %h want 00000000", instr_pc);
    else n_pass++;
    n_checks++;
    if (instr_valid !== 1'b1) $display("FAIL bp valid: got %b want 1", instr_valid);
    else n_pass++;
    // One accepting edge while full: pop and push together.
    instr_ready = 1'b1;
    drain(1, "fullpop");
    instr_ready = 1'b0;
    n_checks++;
    if (imem_addr !== 32'hC) $display("FAIL fullpop imem_addr: got %h want 0000000c", imem_addr);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (imem_addr !== 32'hC) $display("FAIL fullpop count held: got %h want 0000000c", imem_addr);
    else n_pass++;
    n_checks++;
    if (instr_pc !== 32'h4) $display("FAIL fullpop hold pc: got %h want 00000004", instr_pc);
    else n_pass++;
    instr_ready = 1'b1;
    drain(2, "bp");
  endtask

  task automatic test_redirect();
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect    = 1'b0;
    redirect_pc = 32'h5555_5554;
    exp_q.delete();
    n_checks++;
    if (instr_valid !== 1'b0) $display("FAIL redir valid: got %b want 0", instr_valid);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 32'h100) $display("FAIL redir imem_addr: got %h want 00000100", imem_addr);
    else n_pass++;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    @(negedge clk);
    drain(3, "redir");
  endtask

  task automatic test_wrap();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    exp_q.delete();
    n_checks++;
    if (imem_addr !== 32'hFFFF_FFF8) $display("FAIL wrap imem_addr: got %h want fffffff8", imem_addr);
    else n_pass++;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    @(negedge clk);
    drain(4, "wrap");
  endtask

  task automatic test_reset_midstream();
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    reset_n  = 1'b1;
    redirect = 1'b0;
    exp_q.delete();
    n_checks++;
    if (instr_valid !== 1'b0) $display("FAIL midrst valid: got %b want 0", instr_valid);
    else n_pass++;
    n_checks++;
    if (imem_addr !== 32'h0) $display("FAIL midrst imem_addr: got %h want 00000000", imem_addr);
    else n_pass++;
    n_checks++;
    if (instr_pc !== 32'h0) $display("FAIL midrst instr_pc: got %h want 00000000", instr_pc);
    else n_pass++;
    instr_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    @(negedge clk);
    drain(2, "midrst");
  endtask

  initial begin
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    test_reset_stream();
    test_backpressure_full_pop();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    n_checks++;
    if (we_bad !== 1'b0) $display("FAIL imem_we: got %b want 0", we_bad);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
